// File: rtl/memory_access_sequencer.sv
// Sequences two-byte instruction fetches (PC -> IR) and four-byte little-endian
// stores of the ALU result (ALUOut -> mem[AR]) over a valid/ready request port.
//
// state | meaning
// IDLE  | ready for a request, memory deselected
// F_LO  | read mem[PC] into IR[7:0], PC++
// F_HI  | read mem[PC] into IR[15:8], PC++
// STORE | write ALUOut byte cnt to mem[AR], AR++, cnt++
module memory_access_sequencer #(
  parameter logic [1:0] ARF_INC_FUN  = 2'b01,
  parameter logic [2:0] ARF_SEL_NONE = 3'b000,
  parameter logic [2:0] ARF_SEL_PC   = 3'b100,
  parameter logic [2:0] ARF_SEL_AR   = 3'b010,
  parameter logic [1:0] OUTD_PC      = 2'b00,
  parameter logic [1:0] OUTD_AR      = 2'b10,
  parameter logic       MEM_CS_EN    = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req_Valid,
  input  logic       Req_Op,
  output logic       Req_Ready,
  output logic       Done,
  output logic [1:0] ARF_OutDSel,
  output logic [1:0] ARF_FunSel,
  output logic [2:0] ARF_RegSel,
  output logic       Mem_CS,
  output logic       Mem_WR,
  output logic       IR_Write,
  output logic       IR_LH,
  output logic [1:0] MuxCSel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_LO  = 2'd1,
    F_HI  = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       done_next;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      Done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = 2'd0;
        if (Req_Valid) begin
          state_next = Req_Op ? STORE : F_LO;
        end
      end
      F_LO: begin
        state_next = F_HI;
      end
      F_HI: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      STORE: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs: nothing here depends on Req_Valid or Req_Op.
  always_comb begin
    Req_Ready   = 1'b0;
    ARF_OutDSel = OUTD_PC;
    ARF_RegSel  = ARF_SEL_NONE;
    Mem_CS      = ~MEM_CS_EN;
    Mem_WR      = 1'b0;
    IR_Write    = 1'b0;
    IR_LH       = 1'b0;
    MuxCSel     = 2'd0;
    case (state)
      IDLE: begin
        Req_Ready = 1'b1;
      end
      F_LO, F_HI: begin
        ARF_OutDSel = OUTD_PC;
        ARF_RegSel  = ARF_SEL_PC;
        Mem_CS      = MEM_CS_EN;
        IR_Write    = 1'b1;
        IR_LH       = (state == F_HI);
      end
      STORE: begin
        ARF_OutDSel = OUTD_AR;
        ARF_RegSel  = ARF_SEL_AR;
        Mem_CS      = MEM_CS_EN;
        Mem_WR      = 1'b1;
        MuxCSel     = cnt;
      end
      default: begin
        Req_Ready = 1'b0;
      end
    endcase
  end

  assign ARF_FunSel = ARF_INC_FUN;

endmodule
